// File: rtl/deriv_peak_detector.sv
// deriv_peak_detector
//   Peak finder on a Q10.22 signed derivative stream. A peak is recognised
//   when the derivative rises strictly above 'thresh' and later crosses to a
//   value <= 0. Each peak produces a one-cycle event that carries the index
//   of the crossing sample and the largest derivative seen during the rise.
//   After an event, a refractory window ignores REFRACT valid samples. A rise
//   that lasts MAX_RISE samples without crossing is discarded.
//
// Ports
//   clk         rising-edge clock
//   n_rst       asynchronous active-low reset
//   in_valid    'in' carries a new derivative sample this cycle
//   in          derivative sample, signed Q10.22
//   thresh      arming threshold, signed Q10.22, taken with each valid sample
//   peak_valid  one-cycle pulse: a peak was detected
//   peak_idx    index of the crossing sample (first sample with in <= 0)
//   peak_slope  maximum derivative seen during the rise, signed Q10.22
//   state       current FSM state (debug): 0 IDLE, 1 RISE, 2 REFRACT
module deriv_peak_detector #(
    parameter int WIDTH    = 32,
    parameter int CNT_W    = 16,
    parameter int REFRACT  = 8,
    parameter int MAX_RISE = 64
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in,
    input  logic [WIDTH-1:0] thresh,
    output logic             peak_valid,
    output logic [CNT_W-1:0] peak_idx,
    output logic [WIDTH-1:0] peak_slope,
    output logic [1:0]       state
);

    localparam int RISE_W = $clog2(MAX_RISE + 1);
    localparam int REF_W  = $clog2(REFRACT + 2);

    localparam logic [RISE_W-1:0] RISE_LAST = RISE_W'(MAX_RISE - 1);
    localparam logic [REF_W-1:0]  REF_LOAD  = (REFRACT > 0) ? REF_W'(REFRACT - 1) : '0;
    localparam logic signed [WIDTH-1:0] ZERO = '0;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RISE    = 2'd1,
        S_REFRACT = 2'd2,
        S_BAD     = 2'd3
    } state_t;

    state_t cur_st, nxt_st;

    // Input capture stage: the sample is accepted at one edge and evaluated
    // by the FSM at the next, so the event pulse starts one clock after the
    // crossing sample is accepted.
    logic                    s_valid;
    logic signed [WIDTH-1:0] s_in;
    logic signed [WIDTH-1:0] s_thr;

    logic [CNT_W-1:0]        sample_idx;
    logic signed [WIDTH-1:0] max_r, max_n;
    logic [RISE_W-1:0]       rise_cnt, rise_n;
    logic [REF_W-1:0]        ref_cnt, ref_n;
    logic                    fire;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            s_valid <= 1'b0;
            s_in    <= '0;
            s_thr   <= '0;
        end else begin
            s_valid <= in_valid;
            s_in    <= in;
            s_thr   <= thresh;
        end
    end

    // State register and per-sample bookkeeping.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cur_st     <= S_IDLE;
            max_r      <= '0;
            rise_cnt   <= '0;
            ref_cnt    <= '0;
            sample_idx <= '0;
        end else begin
            cur_st   <= nxt_st;
            max_r    <= max_n;
            rise_cnt <= rise_n;
            ref_cnt  <= ref_n;
            if (s_valid) begin
                sample_idx <= sample_idx + 1'b1;
            end
        end
    end

    // Next-state logic; only a valid sample moves anything, except the
    // unreachable encoding which always returns to IDLE.
    always_comb begin
        nxt_st = cur_st;
        max_n  = max_r;
        rise_n = rise_cnt;
        ref_n  = ref_cnt;
        fire   = 1'b0;
        case (cur_st)
            S_IDLE: begin
                if (s_valid && (s_in > s_thr)) begin
                    nxt_st = S_RISE;
                    max_n  = s_in;
                    rise_n = '0;
                end
            end
            S_RISE: begin
                if (s_valid) begin
                    if (s_in <= ZERO) begin
                        // Crossing wins over the rise timeout.
                        fire  = 1'b1;
                        ref_n = REF_LOAD;
                        if (REFRACT == 0) begin
                            nxt_st = S_IDLE;
                        end else begin
                            nxt_st = S_REFRACT;
                        end
                    end else if (rise_cnt == RISE_LAST) begin
                        nxt_st = S_IDLE;
                    end else begin
                        rise_n = rise_cnt + 1'b1;
                        if (s_in > max_r) begin
                            max_n = s_in;
                        end
                    end
                end
            end
            S_REFRACT: begin
                if (s_valid) begin
                    if (ref_cnt == '0) begin
                        nxt_st = S_IDLE;
                    end else begin
                        ref_n = ref_cnt - 1'b1;
                    end
                end
            end
            default: begin
                nxt_st = S_IDLE;
            end
        endcase
    end

    // Event outputs: pulse for one cycle, index/slope held until next event.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            peak_valid <= 1'b0;
            peak_idx   <= '0;
            peak_slope <= '0;
        end else begin
            peak_valid <= fire;
            if (fire) begin
                peak_idx   <= sample_idx;
                peak_slope <= max_r;
            end
        end
    end

    assign state = cur_st;

endmodule

// File: tb/tb_deriv_peak_detector.sv
module tb_deriv_peak_detector;

    localparam logic [31:0] P1   = 32'h0040_0000;   //  1.0
    localparam logic [31:0] P075 = 32'h0030_0000;   //  0.75
    localparam logic [31:0] P05  = 32'h0020_0000;   //  0.5
    localparam logic [31:0] TH   = 32'h0010_0000;   //  0.25
    localparam logic [31:0] P02  = 32'h000C_CCCD;   //  0.2
    localparam logic [31:0] N02  = 32'hFFF3_3333;   // -0.2
    localparam logic [31:0] N01  = 32'hFFF9_999A;   // -0.1
    localparam logic [31:0] N05  = 32'hFFE0_0000;   // -0.5

    logic        clk;
    logic        n_rst;
    logic        in_valid;
    logic [31:0] in_v;
    logic [31:0] thresh;
    logic        peak_valid;
    logic [15:0] peak_idx;
    logic [31:0] peak_slope;
    logic [1:0]  state;

    logic [31:0] thr_v;

    typedef struct {
        longint      t;
        logic [15:0] idx;
        logic [31:0] slope;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    deriv_peak_detector #(
        .WIDTH(32),
        .CNT_W(16),
        .REFRACT(8),
        .MAX_RISE(64)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .in_valid(in_valid),
        .in(in_v),
        .thresh(thresh),
        .peak_valid(peak_valid),
        .peak_idx(peak_idx),
        .peak_slope(peak_slope),
        .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Issue one valid sample; if it is a crossing that must fire, queue the
    // expected event tagged with the edge time at which it was accepted.
    task automatic send(input logic [31:0] d, input bit ev,
                        input logic [15:0] ei, input logic [31:0] es);
        exp_t e;
        in_v     = d;
        thresh   = thr_v;
        in_valid = 1'b1;
        @(posedge clk);
        if (ev) begin
            e.t     = longint'($time);
            e.idx   = ei;
            e.slope = es;
            sb.push_back(e);
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 n_rst = 1'b0;
        @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Monitor: the pulse must appear at the negedge 1.5 periods after the
    // crossing sample's accept edge and match the queued index/slope.
    always @(negedge clk) begin
        if (n_rst && peak_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_peak", {16'h0, peak_idx}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("peak_idx",   {16'h0, peak_idx}, {16'h0, e.idx});
                chk("peak_slope", peak_slope, e.slope);
                chk("peak_time",  32'(longint'($time) - e.t), 32'd15);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst    = 1'b1;
        in_valid = 1'b0;
        in_v     = '0;
        thr_v    = TH;
        thresh   = TH;
        #1 n_rst = 1'b0;
        #1;
        chk("rst_valid", {31'h0, peak_valid}, 32'h0);
        chk("rst_idx",   {16'h0, peak_idx},   32'h0);
        chk("rst_slope", peak_slope,          32'h0);
        chk("rst_state", {30'h0, state},      32'h0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        idle(1);

        // Basic peak: max slope 1.0, crossing at index 4.
        send(32'h0, 0, 0, 0);
        send(P05,   0, 0, 0);
        send(P1,    0, 0, 0);
        send(P075,  0, 0, 0);
        send(N01,   1, 16'd4, P1);
        idle(3);

        // Mid-stream reset with a crossing pending: pulse dropped, outputs
        // cleared immediately, index restarts at 0.
        for (int i = 0; i < 8; i++) send(32'h0, 0, 0, 0);
        send(P05, 0, 0, 0);
        send(N01, 0, 0, 0);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", {31'h0, peak_valid}, 32'h0);
        chk("mid_rst_idx",   {16'h0, peak_idx},   32'h0);
        chk("mid_rst_slope", peak_slope,          32'h0);
        chk("mid_rst_state", {30'h0, state},      32'h0);
        @(posedge clk);
        #3 n_rst = 1'b1;
        idle(1);
        send(P05, 0, 0, 0);
        send(N01, 1, 16'd1, P05);
        idle(3);

        // Never above threshold (0.2, and exactly 0.25): no event.
        do_reset();
        for (int i = 0; i < 4; i++) send(P02, 0, 0, 0);
        send(TH,  0, 0, 0);
        send(N02, 0, 0, 0);
        idle(3);
        chk("below_thresh_state", {30'h0, state}, 32'h0);

        // Refractory window: samples 5..12 ignored, 13 arms, 14 fires.
        do_reset();
        send(32'h0, 0, 0, 0);
        send(P05,   0, 0, 0);
        send(P1,    0, 0, 0);
        send(P075,  0, 0, 0);
        send(N01,   1, 16'd4, P1);
        for (int k = 5; k <= 14; k++) begin
            if (k % 2 == 1) send(P05, 0, 0, 0);
            else            send(N05, (k == 14), 16'(k), P05);
        end
        idle(3);
        chk("refract_state", {30'h0, state}, 32'h2);

        // Rise timeout: 0..63 keep RISE, 64 aborts, 65 crossing ignored.
        do_reset();
        for (int i = 0; i < 64; i++) send(P05, 0, 0, 0);
        idle(2);
        chk("rise_before_abort", {30'h0, state}, 32'h1);
        send(P05, 0, 0, 0);
        idle(2);
        chk("rise_abort_state", {30'h0, state}, 32'h0);
        send(N05, 0, 0, 0);
        idle(3);
        chk("after_abort_state", {30'h0, state}, 32'h0);

        // Basic peak with 3-cycle gaps between samples.
        do_reset();
        send(32'h0, 0, 0, 0); idle(3);
        send(P05,   0, 0, 0); idle(3);
        send(P1,    0, 0, 0); idle(3);
        send(P075,  0, 0, 0); idle(3);
        send(N01,   1, 16'd4, P1);
        idle(4);

        // Negative threshold: -0.1 > -0.5 only arms; the next -0.1 fires.
        do_reset();
        thr_v = N05;
        send(N01, 0, 0, 0);
        idle(2);
        chk("neg_thresh_arm", {30'h0, state}, 32'h1);
        send(N01, 1, 16'd1, N01);
        idle(3);
        thr_v = TH;

        for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
